// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_MAX   = 5;

  // Decoded register address: raw index plus "names a real, writable register".
  typedef struct packed {
    logic              valid;
    logic [AW_MAX-1:0] addr;
  } reg_addr_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic reg_addr_t make_addr(input logic [AW_MAX-1:0] a, input int unsigned nreg);
    reg_addr_t r;
    r.addr  = a;
    r.valid = (a != '0) && (32'(a) < nreg);
    return r;
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter of outstanding writes to one architectural register.
module pend_counter #(
  parameter int unsigned CW   = 2,
  parameter int unsigned MAXV = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          max_o,
  output logic          nz_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CW'(MAXV))) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign max_o = (cnt_q == CW'(MAXV));
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// RV32I-style register file (2R/1W, optional write bypass) with per-register
// pending-write scoreboard. Define REGFILE_DBG_EN to add DbgRa/DbgBus/DbgPend.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN    = XLEN_DEF,
  parameter  int unsigned NREG    = NREG_DEF,
  parameter  int unsigned MAXPEND = 3,
  parameter  int unsigned BYPASS  = 1,
  localparam int unsigned AW      = clog2_min1(NREG)
) (
  input  logic            WrClk,
  input  logic            Rst_n,
  input  logic [AW-1:0]   Ra,
  input  logic [AW-1:0]   Rb,
  output logic [XLEN-1:0] busA,
  output logic [XLEN-1:0] busB,
  output logic            BusyA,
  output logic            BusyB,
  input  logic [AW-1:0]   Rw,
  input  logic [XLEN-1:0] busW,
  input  logic            RegWr,
  input  logic            IssVld,
  input  logic [AW-1:0]   IssRd,
`ifdef REGFILE_DBG_EN
  input  logic [AW-1:0]   DbgRa,
  output logic [XLEN-1:0] DbgBus,
  output logic [NREG-1:1] DbgPend,
`endif
  output logic            IssRdy
);

  localparam int unsigned CW = clog2_min1(MAXPEND + 1);

  reg_addr_t ra_s, rb_s, rw_s, iss_s;

  assign ra_s  = make_addr(AW_MAX'(Ra), NREG);
  assign rb_s  = make_addr(AW_MAX'(Rb), NREG);
  assign rw_s  = make_addr(AW_MAX'(Rw), NREG);
  assign iss_s = make_addr(AW_MAX'(IssRd), NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic            we;
  logic            acc;
  logic            ret;
  logic [NREG-1:0] nz_w;
  logic [NREG-1:0] max_w;
  logic [CW-1:0]   cnt_w [NREG];

  assign we = RegWr && rw_s.valid;

  // Register array; entry 0 is never written so it reads as zero.
  always_ff @(posedge WrClk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[Rw] <= busW;
    end
  end

  assign acc = IssVld && IssRdy && iss_s.valid;
  assign ret = we && nz_w[Rw];

  assign nz_w[0]  = 1'b0;
  assign max_w[0] = 1'b0;
  assign cnt_w[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    pend_counter #(
      .CW   (CW),
      .MAXV (MAXPEND)
    ) u_cnt (
      .clk   (WrClk),
      .rst_n (Rst_n),
      .inc_i (acc && (iss_s.addr == AW_MAX'(r))),
      .dec_i (ret && (rw_s.addr == AW_MAX'(r))),
      .cnt_o (cnt_w[r]),
      .max_o (max_w[r]),
      .nz_o  (nz_w[r])
    );
  end

  // A saturated destination stalls issue; a same-cycle retire gives no credit.
  always_comb begin
    IssRdy = 1'b1;
    if (iss_s.valid) begin
      IssRdy = !max_w[IssRd];
    end
  end

  // Read port A: data and busy, with optional forwarding of the writeback.
  always_comb begin
    busA  = '0;
    BusyA = 1'b0;
    if (ra_s.valid) begin
      if ((BYPASS != 0) && we && (rw_s.addr == ra_s.addr)) begin
        busA = busW;
      end else begin
        busA = regs_q[Ra];
      end
      if (BYPASS != 0) begin
        BusyA = nz_w[Ra] && !(ret && (rw_s.addr == ra_s.addr) && (cnt_w[Ra] == CW'(1)));
      end else begin
        BusyA = nz_w[Ra];
      end
    end
  end

  // Read port B mirrors port A.
  always_comb begin
    busB  = '0;
    BusyB = 1'b0;
    if (rb_s.valid) begin
      if ((BYPASS != 0) && we && (rw_s.addr == rb_s.addr)) begin
        busB = busW;
      end else begin
        busB = regs_q[Rb];
      end
      if (BYPASS != 0) begin
        BusyB = nz_w[Rb] && !(ret && (rw_s.addr == rb_s.addr) && (cnt_w[Rb] == CW'(1)));
      end else begin
        BusyB = nz_w[Rb];
      end
    end
  end

`ifdef REGFILE_DBG_EN
  logic [XLEN-1:0] dbg_bus_q, dbg_bus_d;

  always_comb begin
    dbg_bus_d = '0;
    if ((DbgRa != '0) && (32'(DbgRa) < NREG)) begin
      dbg_bus_d = regs_q[DbgRa];
    end
  end

  always_ff @(posedge WrClk or negedge Rst_n) begin
    if (!Rst_n) begin
      dbg_bus_q <= '0;
    end else begin
      dbg_bus_q <= dbg_bus_d;
    end
  end

  assign DbgBus  = dbg_bus_q;
  assign DbgPend = nz_w[NREG-1:1];
`endif

endmodule
